winograd_pe: RTL and testbench

- Processing element of the Winograd CNN systolic array.
- Takes a 6x6 transformed input tile (U) and a 6x6 transformed weight tile (V) and forms their element-wise (Hadamard) product, scaled to 12 bits.
- Tags each result with output-depth and per-element pixel coordinates.
- Forwards its input tile, weight tile and sideband signals, one cycle delayed, to neighbouring PEs.

---
 rtl/winograd_pkg.sv | 21 ++
 rtl/winograd_pe_if.sv | 50 +++++
 rtl/pe_mul_scale.sv | 44 ++++
 rtl/winograd_pe.sv | 120 ++++++++++++
 tb/tb_winograd_pe.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/winograd_pkg.sv
// Shared parameters and tile types for the Winograd processing element.
// Contents:
//   TILE, DATA_W, WEIGHT_W, RES_W, IDX_W, OD_W, SHIFT : geometry and arithmetic widths
//   data_tile_t, weight_tile_t, result_tile_t, index_tile_t : packed TILE x TILE tiles
// Tile elements are stored as raw bits. Consumers reinterpret them as signed where needed.
package winograd_pkg;

    localparam int unsigned TILE     = 6;
    localparam int unsigned DATA_W   = 14;
    localparam int unsigned WEIGHT_W = 12;
    localparam int unsigned RES_W    = 12;
    localparam int unsigned IDX_W    = 9;
    localparam int unsigned OD_W     = 8;
    localparam int unsigned SHIFT    = 8;

    typedef logic [TILE-1:0][TILE-1:0][DATA_W-1:0]   data_tile_t;
    typedef logic [TILE-1:0][TILE-1:0][WEIGHT_W-1:0] weight_tile_t;
    typedef logic [TILE-1:0][TILE-1:0][RES_W-1:0]    result_tile_t;
    typedef logic [TILE-1:0][TILE-1:0][IDX_W-1:0]    index_tile_t;

endpackage

// File: rtl/winograd_pe_if.sv
// Bus bundle for one Winograd PE.
// It carries the incoming data/weight tiles with their sideband signals, the result tile
// with its tags, and the registered forwards that feed neighbouring PEs.
// Modports:
//   slave  : the PE side (samples *_i, drives *_o)
//   master : the upstream and neighbour side
interface winograd_pe_if;
    import winograd_pkg::*;

    data_tile_t             data_tile_i;
    logic                   data_valid_i;
    logic [IDX_W-1:0]       data_x_index_i;
    logic [IDX_W-1:0]       data_y_index_i;
    weight_tile_t           weight_tile_i;
    logic                   weight_valid_i;
    logic                   weight_size_type_i;
    logic [OD_W-1:0]        weight_od_i;

    result_tile_t           result_tile_o;
    logic [OD_W-1:0]        result_od_o;
    index_tile_t            result_i_o;
    index_tile_t            result_j_o;
    logic                   result_valid_o;

    data_tile_t             data_tile_reg_o;
    logic                   data_valid_o;
    logic [IDX_W-1:0]       data_x_index_o;
    logic [IDX_W-1:0]       data_y_index_o;
    weight_tile_t           weight_tile_reg_o;
    logic                   weight_valid_o;
    logic                   weight_size_type_o;
    logic [OD_W-1:0]        weight_od_o;

    modport slave (
        input  data_tile_i, data_valid_i, data_x_index_i, data_y_index_i,
        input  weight_tile_i, weight_valid_i, weight_size_type_i, weight_od_i,
        output result_tile_o, result_od_o, result_i_o, result_j_o, result_valid_o,
        output data_tile_reg_o, data_valid_o, data_x_index_o, data_y_index_o,
        output weight_tile_reg_o, weight_valid_o, weight_size_type_o, weight_od_o
    );

    modport master (
        output data_tile_i, data_valid_i, data_x_index_i, data_y_index_i,
        output weight_tile_i, weight_valid_i, weight_size_type_i, weight_od_i,
        input  result_tile_o, result_od_o, result_i_o, result_j_o, result_valid_o,
        input  data_tile_reg_o, data_valid_o, data_x_index_o, data_y_index_o,
        input  weight_tile_reg_o, weight_valid_o, weight_size_type_o, weight_od_o
    );

endinterface

// File: rtl/pe_mul_scale.sv
// Combinational multiply-and-scale for a single tile element.
// The output is (data * weight) >>> SHIFT, narrowed to RES_W bits.
// Optional macro SATURATE_EN: clamp to the RES_W signed range instead of wrapping.
// Ports:
//   data_i     : signed data element (DATA_W)
//   weight_i   : signed weight element (WEIGHT_W)
//   scaled_c_o : combinational scaled result (RES_W)
module pe_mul_scale
    import winograd_pkg::*;
(
    input  logic signed [DATA_W-1:0]   data_i,
    input  logic signed [WEIGHT_W-1:0] weight_i,
    output logic signed [RES_W-1:0]    scaled_c_o
);

    localparam int unsigned PROD_W = DATA_W + WEIGHT_W;

    logic signed [PROD_W-1:0] prod_c;

    // Sign-extend both operands to the full product width so the product is exact.
    assign prod_c = PROD_W'(data_i) * PROD_W'(weight_i);

`ifdef SATURATE_EN
    localparam logic signed [PROD_W-1:0] SAT_MAX = (PROD_W'(1) <<< (RES_W - 1)) - PROD_W'(1);
    localparam logic signed [PROD_W-1:0] SAT_MIN = -SAT_MAX - PROD_W'(1);

    logic signed [PROD_W-1:0] shifted_c;

    // Floor-shift the product, then clamp it to the signed result range.
    always_comb begin
        shifted_c  = prod_c >>> SHIFT;
        scaled_c_o = RES_W'(shifted_c);
        if (shifted_c > SAT_MAX) begin
            scaled_c_o = RES_W'(SAT_MAX);
        end else if (shifted_c < SAT_MIN) begin
            scaled_c_o = RES_W'(SAT_MIN);
        end
    end
`else
    // Floor-shift the product, then keep only the low RES_W bits (two's-complement wrap).
    assign scaled_c_o = RES_W'(prod_c >>> SHIFT);
`endif

endmodule

// File: rtl/winograd_pe.sv
// Winograd systolic-array processing element.
// Stage 1 registers every input unconditionally and forwards it to the neighbouring PEs.
// Stage 2 forms the scaled Hadamard product of the forwarded tiles. The product is tagged
// with output depth and per-element pixel coordinates. Result latency is 2 cycles.
// Optional macro SATURATE_EN (in pe_mul_scale): saturate results instead of wrapping.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous reset, active low
//   pe_if : winograd_pe_if.slave bundle (tiles, valids, indices, result, forwards)
module winograd_pe
    import winograd_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    winograd_pe_if.slave  pe_if
);

    data_tile_t       data_tile_q;
    logic             data_valid_q;
    logic [IDX_W-1:0] data_x_q;
    logic [IDX_W-1:0] data_y_q;
    weight_tile_t     weight_tile_q;
    logic             weight_valid_q;
    logic             weight_st_q;
    logic [OD_W-1:0]  weight_od_q;

    result_tile_t     result_tile_q;
    logic [OD_W-1:0]  result_od_q;
    index_tile_t      result_i_q;
    index_tile_t      result_j_q;
    logic             result_valid_q;

    result_tile_t     result_tile_d;
    index_tile_t      result_i_d;
    index_tile_t      result_j_d;
    logic             fire_c;

    // Forward stage: unconditional capture of all inputs, valids included.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_tile_q    <= '0;
            data_valid_q   <= 1'b0;
            data_x_q       <= '0;
            data_y_q       <= '0;
            weight_tile_q  <= '0;
            weight_valid_q <= 1'b0;
            weight_st_q    <= 1'b0;
            weight_od_q    <= '0;
        end else begin
            data_tile_q    <= pe_if.data_tile_i;
            data_valid_q   <= pe_if.data_valid_i;
            data_x_q       <= pe_if.data_x_index_i;
            data_y_q       <= pe_if.data_y_index_i;
            weight_tile_q  <= pe_if.weight_tile_i;
            weight_valid_q <= pe_if.weight_valid_i;
            weight_st_q    <= pe_if.weight_size_type_i;
            weight_od_q    <= pe_if.weight_od_i;
        end
    end

    assign fire_c = data_valid_q & weight_valid_q;

    // One multiply/scale lane per tile element.
    for (genvar r = 0; r < TILE; r++) begin : g_row
        for (genvar c = 0; c < TILE; c++) begin : g_col
            pe_mul_scale u_mul (
                .data_i     (data_tile_q[r][c]),
                .weight_i   (weight_tile_q[r][c]),
                .scaled_c_o (result_tile_d[r][c])
            );
        end
    end

    // Per-element pixel coordinates; additions wrap modulo 2^IDX_W.
    always_comb begin
        result_i_d = '0;
        result_j_d = '0;
        for (int unsigned r = 0; r < TILE; r++) begin
            for (int unsigned c = 0; c < TILE; c++) begin
                result_i_d[r][c] = data_x_q + IDX_W'(r);
                result_j_d[r][c] = data_y_q + IDX_W'(c);
            end
        end
    end

    // Result stage: payload updates only on fire, valid tracks fire every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_tile_q  <= '0;
            result_od_q    <= '0;
            result_i_q     <= '0;
            result_j_q     <= '0;
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= fire_c;
            if (fire_c) begin
                result_tile_q <= result_tile_d;
                result_od_q   <= weight_od_q;
                result_i_q    <= result_i_d;
                result_j_q    <= result_j_d;
            end
        end
    end

    assign pe_if.data_tile_reg_o    = data_tile_q;
    assign pe_if.data_valid_o       = data_valid_q;
    assign pe_if.data_x_index_o     = data_x_q;
    assign pe_if.data_y_index_o     = data_y_q;
    assign pe_if.weight_tile_reg_o  = weight_tile_q;
    assign pe_if.weight_valid_o     = weight_valid_q;
    assign pe_if.weight_size_type_o = weight_st_q;
    assign pe_if.weight_od_o        = weight_od_q;

    assign pe_if.result_tile_o  = result_tile_q;
    assign pe_if.result_od_o    = result_od_q;
    assign pe_if.result_i_o     = result_i_q;
    assign pe_if.result_j_o     = result_j_q;
    assign pe_if.result_valid_o = result_valid_q;

endmodule

// File: tb/tb_winograd_pe.sv
// Directed self-checking bench for winograd_pe.
// Build with or without SATURATE_EN; overflow expectations follow the macro.
module tb_winograd_pe;
    import winograd_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    winograd_pe_if pe_if ();

    winograd_pe dut (
        .clk   (clk),
        .reset (reset),
        .pe_if (pe_if.slave)
    );

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one cycle; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input int w, input bit dv, input bit wv,
                         input int x, input int y, input int od, input bit st);
        for (int r = 0; r < int'(TILE); r++) begin
            for (int c = 0; c < int'(TILE); c++) begin
                pe_if.data_tile_i[r][c]   = DATA_W'(d);
                pe_if.weight_tile_i[r][c] = WEIGHT_W'(w);
            end
        end
        pe_if.data_valid_i       = dv;
        pe_if.weight_valid_i     = wv;
        pe_if.data_x_index_i     = IDX_W'(x);
        pe_if.data_y_index_i     = IDX_W'(y);
        pe_if.weight_od_i        = OD_W'(od);
        pe_if.weight_size_type_i = st;
    endtask

    task automatic valids(input bit dv, input bit wv);
        pe_if.data_valid_i   = dv;
        pe_if.weight_valid_i = wv;
    endtask

    // Reference element: exact product, floor shift, then clamp or wrap to 12 bits.
    function automatic int model(input int d, input int w);
        int p;
        int s;
        logic signed [11:0] t;
        p = d * w;
        s = p >>> 8;
`ifdef SATURATE_EN
        if (s > 2047) s = 2047;
        if (s < -2048) s = -2048;
        return s;
`else
        t = s[11:0];
        return int'(t);
`endif
    endfunction

    task automatic check_tile_uniform(input string tag, input int exp);
        for (int r = 0; r < int'(TILE); r++) begin
            for (int c = 0; c < int'(TILE); c++) begin
                check($sformatf("%s[%0d][%0d]", tag, r, c),
                      32'($signed(pe_if.result_tile_o[r][c])), exp);
            end
        end
    endtask

    int ovf_exp;
    int dd;
    int ww;

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #12;
        check("rst_result_valid", 32'(pe_if.result_valid_o), 0);
        check("rst_data_valid",   32'(pe_if.data_valid_o), 0);
        reset = 1'b1;
        step();

        // Basic: 256*3 = 768, 768>>>8 = 3
        drive(256, 3, 1, 1, 10, 15, 3, 1);
        step();
        check("fwd_data_valid",   32'(pe_if.data_valid_o), 1);
        check("fwd_weight_valid", 32'(pe_if.weight_valid_o), 1);
        check("fwd_x",            32'(pe_if.data_x_index_o), 10);
        check("fwd_y",            32'(pe_if.data_y_index_o), 15);
        check("fwd_od",           32'(pe_if.weight_od_o), 3);
        check("fwd_size_type",    32'(pe_if.weight_size_type_o), 1);
        check("fwd_data_00",      32'(pe_if.data_tile_reg_o[0][0]), 256);
        check("fwd_weight_55",    32'(pe_if.weight_tile_reg_o[5][5]), 3);
        check("basic_early_valid", 32'(pe_if.result_valid_o), 0);
        valids(0, 0);
        step();
        check("basic_valid", 32'(pe_if.result_valid_o), 1);
        check("basic_od",    32'(pe_if.result_od_o), 3);
        check_tile_uniform("basic_tile", 3);
        for (int k = 0; k < int'(TILE); k++) begin
            check($sformatf("basic_i[%0d][2]", k), 32'(pe_if.result_i_o[k][2]), 10 + k);
            check($sformatf("basic_j[1][%0d]", k), 32'(pe_if.result_j_o[1][k]), 15 + k);
        end

        // Valid gating: data valid only, payload must hold, valids forwarded as driven
        drive(1000, 7, 1, 0, 40, 41, 9, 0);
        step();
        check("gate_fwd_dv", 32'(pe_if.data_valid_o), 1);
        check("gate_fwd_wv", 32'(pe_if.weight_valid_o), 0);
        check("gate_valid_mid", 32'(pe_if.result_valid_o), 0);
        valids(0, 1);
        step();
        check("gate_valid", 32'(pe_if.result_valid_o), 0);
        check("gate_fwd_dv2", 32'(pe_if.data_valid_o), 0);
        check("gate_fwd_wv2", 32'(pe_if.weight_valid_o), 1);
        check("gate_hold_23", 32'($signed(pe_if.result_tile_o[2][3])), 3);
        check("gate_hold_od", 32'(pe_if.result_od_o), 3);
        check("gate_hold_i",  32'(pe_if.result_i_o[4][0]), 14);
        valids(0, 0);
        step();
        check("gate_valid2", 32'(pe_if.result_valid_o), 0);

        // Sign: -300*5 = -1500, floor(-1500/256) = -6
        drive(-300, 5, 1, 1, 0, 0, 17, 0);
        step();
        valids(0, 0);
        step();
        check("neg_valid", 32'(pe_if.result_valid_o), 1);
        check("neg_od",    32'(pe_if.result_od_o), 17);
        check_tile_uniform("neg_tile", -6);

        // Sign: -1*1 = -1, floor(-1/256) = -1; back-to-back with next vector
        drive(-1, 1, 1, 1, 0, 0, 18, 0);
        step();
        // Overflow: 8191*2047 = 16766977, >>>8 = 65496 -> wrap to -40, or clamp to 2047
        drive(8191, 2047, 1, 1, 0, 0, 19, 0);
        step();
        check("m1_valid", 32'(pe_if.result_valid_o), 1);
        check_tile_uniform("m1_tile", -1);
        valids(0, 0);
        step();
`ifdef SATURATE_EN
        ovf_exp = 2047;
`else
        ovf_exp = -40;
`endif
        check("ovf_valid", 32'(pe_if.result_valid_o), 1);
        check("ovf_od",    32'(pe_if.result_od_o), 19);
        check_tile_uniform("ovf_tile", ovf_exp);

        // Negative overflow: -8192*2047 = -16769024, >>>8 = -65504 -> wrap 32, or clamp -2048
        drive(-8192, 2047, 1, 1, 0, 0, 20, 0);
        step();
        valids(0, 0);
        step();
`ifdef SATURATE_EN
        ovf_exp = -2048;
`else
        ovf_exp = 32;
`endif
        check_tile_uniform("novf_tile", ovf_exp);

        // Index wrap: 510+5 = 515 -> 3, 508+5 = 513 -> 1 (mod 512)
        drive(0, 0, 1, 1, 510, 508, 1, 0);
        step();
        valids(0, 0);
        step();
        for (int k = 0; k < int'(TILE); k++) begin
            check($sformatf("wrap_i[5][%0d]", k), 32'(pe_if.result_i_o[5][k]), 3);
            check($sformatf("wrap_j[%0d][5]", k), 32'(pe_if.result_j_o[k][5]), 1);
        end
        check("wrap_i00", 32'(pe_if.result_i_o[0][0]), 510);
        check("wrap_j00", 32'(pe_if.result_j_o[0][0]), 508);

        // Distinct per-element operands to catch lane wiring errors
        for (int r = 0; r < int'(TILE); r++) begin
            for (int c = 0; c < int'(TILE); c++) begin
                pe_if.data_tile_i[r][c]   = DATA_W'((r * 6 + c) * 211 - 3700);
                pe_if.weight_tile_i[r][c] = WEIGHT_W'((c * 6 + r) * 97 - 1700);
            end
        end
        valids(1, 1);
        step();
        valids(0, 0);
        step();
        for (int r = 0; r < int'(TILE); r++) begin
            for (int c = 0; c < int'(TILE); c++) begin
                dd = (r * 6 + c) * 211 - 3700;
                ww = (c * 6 + r) * 97 - 1700;
                check($sformatf("mix[%0d][%0d]", r, c),
                      32'($signed(pe_if.result_tile_o[r][c])), model(dd, ww));
            end
        end

        // Mid-stream asynchronous reset with valids high
        drive(256, 3, 1, 1, 10, 15, 3, 1);
        step();
        step();
        check("pre_rst_valid", 32'(pe_if.result_valid_o), 1);
        #1;
        reset = 1'b0;
        #1;
        check("arst_result_valid", 32'(pe_if.result_valid_o), 0);
        check("arst_data_valid",   32'(pe_if.data_valid_o), 0);
        check("arst_weight_valid", 32'(pe_if.weight_valid_o), 0);
        check("arst_od",           32'(pe_if.result_od_o), 0);
        check("arst_fwd_od",       32'(pe_if.weight_od_o), 0);
        check("arst_fwd_x",        32'(pe_if.data_x_index_o), 0);
        check("arst_size_type",    32'(pe_if.weight_size_type_o), 0);
        check("arst_i_tile",       32'(pe_if.result_i_o != '0), 0);
        check("arst_j_tile",       32'(pe_if.result_j_o != '0), 0);
        check("arst_data_tile",    32'(pe_if.data_tile_reg_o != '0), 0);
        check("arst_weight_tile",  32'(pe_if.weight_tile_reg_o != '0), 0);
        check_tile_uniform("arst_tile", 0);
        step();
        check("arst_hold_valid", 32'(pe_if.result_valid_o), 0);
        reset = 1'b1;
        step();
        check("rel_result_valid", 32'(pe_if.result_valid_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
